bus_cache: RTL
==============

# bus_cache

Direct-mapped, write-through, single-word-per-line cache between the CPU_v2 bus master and the SoC address decoder that fans out to BROM/BRAM. It answers read hits in one cycle from local flops, forwards misses and all writes downstream, and presents the same request/ready bus protocol on both sides, so it drops in between `cpu_*` and the decoder with no change to either.

## Interface
Parameters:
- `INDEX_BITS`, 4: log2 of line count (16 lines); tag width = 30 − INDEX_BITS.

Ports:
- `i_clock`  in  1  single clock; all state changes on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_flush`  in  1  invalidate all lines (single-cycle pulse, acted on in IDLE only).
- `i_request`  in  1  upstream transaction request (from CPU).
- `i_rw`  in  1  1 = write, 0 = read.
- `i_address`  in  32  byte address; bits [1:0] ignored.
- `i_wdata`  in  32  write data.
- `o_rdata`  out  32  read data, valid while `o_ready` = 1.
- `o_ready`  out  1  upstream completion.
- `o_bus_request`  out  1  downstream request.
- `o_bus_rw`  out  1  downstream direction.
- `o_bus_address`  out  32  downstream address (`i_address` passed through, word-aligned).
- `o_bus_wdata`  out  32  downstream write data.
- `i_bus_rdata`  in  32  downstream read data.
- `i_bus_ready`  in  1  downstream completion.

## Operation
- Handshake (both sides): master raises request with address/rw/wdata stable; slave raises ready; ready stays high while request stays high; master drops request; slave drops ready the cycle after. A new request requires request low for at least one sampled edge.
- Index = `i_address[INDEX_BITS+1:2]`; tag = `i_address[31:INDEX_BITS+2]`. Hit = valid[index] && tag[index] == tag.
- States: IDLE, FILL, WRITE, DONE.
- IDLE: if `i_flush` → clear all valid bits, stay IDLE (flush wins over a simultaneous request; request is serviced on the next edge). Else if `i_request`: read hit → load `o_rdata` from line, `o_ready`=1, → DONE; read miss → `o_bus_request`=1, `o_bus_rw`=0, → FILL; write → if hit update line data, `o_bus_request`=1, `o_bus_rw`=1, → WRITE (no write-allocate on miss).
- FILL: on `i_bus_ready` → write line (data, tag, valid=1), `o_rdata`=`i_bus_rdata`, `o_bus_request`=0, `o_ready`=1, → DONE.
- WRITE: on `i_bus_ready` → `o_bus_request`=0, `o_ready`=1, → DONE.
- DONE: hold `o_ready`/`o_rdata`; when `i_request`=0 → `o_ready`=0, → IDLE. `i_flush` in non-IDLE states is ignored (not latched).
- Downstream address/rw/wdata registered at IDLE exit and held constant until `i_bus_ready`.
- No downstream wait timeout; an unmapped address (decoder never readies) hangs the master, matching the SoC's existing behaviour.

## Timing
- Reset: state IDLE, all valid bits 0, `o_ready`=0, `o_rdata`=0, `o_bus_request`=0, `o_bus_rw`=0, `o_bus_address`=0, `o_bus_wdata`=0. Tag/data arrays not reset.
- Reset mid-transaction: abandon; `o_bus_request` low after the reset edge; no line written.
- Read hit: request sampled at edge N → `o_ready` high after edge N (1-cycle latency).
- Miss/write: `o_bus_request` high after edge N; `i_bus_ready` sampled at edge M → `o_ready` high after edge M, `o_bus_request` low after edge M. Total latency = downstream latency + 1.
- `o_ready` falls one cycle after `i_request` is seen low; minimum back-to-back hit period 3 cycles.
- Write hit updates the line at edge N, so a subsequent read returns new data even before the downstream write completes.

## Test plan
- Reset then read 0x00000010 (miss), ROM model returns 0x12345678 after 1 wait → `o_bus_request` one transaction, `o_rdata`=0x12345678; repeat read → hit, `o_ready` 1 cycle after request, no downstream request.
- Read 0x00000010 then 0x00000050 (same index 4, different tag) → second is a miss and evicts; re-read 0x00000010 → miss again.
- Write 0xDEADBEEF to cached 0x00010020 → downstream write seen with that data; read back → hit returning 0xDEADBEEF. Write to uncached 0x00010024 → read afterward is a miss (no allocate).
- Fill 0x00000010, pulse `i_flush` same cycle as read request to it → flush first, read then misses.
- Assert `i_reset` while in FILL with downstream not ready → next cycle `o_bus_request`=0, `o_ready`=0; post-reset read of same address misses.
- Hold `i_request` high 5 cycles after `o_ready` → `o_ready` stays high, `o_rdata` stable, no second transaction.

Source files
------------

// File: rtl/bus_cache.sv
// Direct-mapped write-through cache between CPU bus and SoC decoder: read hits complete in 1 cycle,
// misses and writes cost downstream latency + 1; both sides use request/ready and stall on the missing ready.
module bus_cache #(
   parameter int INDEX_BITS = 4
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_flush,
   input  logic        i_request,
   input  logic        i_rw,
   input  logic [31:0] i_address,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_ready,
   output logic        o_bus_request,
   output logic        o_bus_rw,
   output logic [31:0] o_bus_address,
   output logic [31:0] o_bus_wdata,
   input  logic [31:0] i_bus_rdata,
   input  logic        i_bus_ready
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;

   typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

   state_t                state;
   logic [LINES-1:0]      valid;
   logic [TAG_BITS-1:0]   tag_mem  [LINES];
   logic [31:0]           data_mem [LINES];

   logic [INDEX_BITS-1:0] req_index;
   logic [TAG_BITS-1:0]   req_tag;
   logic [INDEX_BITS-1:0] fill_index;
   logic                  hit;
   logic                  fill_we;
   logic                  write_hit_we;
   logic                  unused_addr_bits;

   assign req_index  = i_address[INDEX_BITS+1:2];
   assign req_tag    = i_address[31:INDEX_BITS+2];
   assign hit        = valid[req_index] && (tag_mem[req_index] == req_tag);
   // The registered downstream address is the fill target; it is held until i_bus_ready.
   assign fill_index = o_bus_address[INDEX_BITS+1:2];

   assign fill_we      = (state == FILL) && i_bus_ready && !i_reset;
   assign write_hit_we = (state == IDLE) && !i_flush && i_request && i_rw && hit && !i_reset;

   assign unused_addr_bits = &{1'b0, i_address[1:0]};

   // Tag/data arrays carry no reset; valid bits alone decide whether a line is usable.
   always_ff @(posedge i_clock) begin
      if (fill_we) begin
         tag_mem[fill_index]  <= o_bus_address[31:INDEX_BITS+2];
         data_mem[fill_index] <= i_bus_rdata;
      end else if (write_hit_we) begin
         data_mem[req_index] <= i_wdata;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state         <= IDLE;
         valid         <= '0;
         o_ready       <= 1'b0;
         o_rdata       <= '0;
         o_bus_request <= 1'b0;
         o_bus_rw      <= 1'b0;
         o_bus_address <= '0;
         o_bus_wdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_flush) begin
                  valid <= '0;
               end else if (i_request) begin
                  if (!i_rw && hit) begin
                     o_rdata <= data_mem[req_index];
                     o_ready <= 1'b1;
                     state   <= DONE;
                  end else begin
                     o_bus_request <= 1'b1;
                     o_bus_rw      <= i_rw;
                     o_bus_address <= {i_address[31:2], 2'b00};
                     o_bus_wdata   <= i_wdata;
                     state         <= i_rw ? WRITE : FILL;
                  end
               end
            end
            FILL: begin
               if (i_bus_ready) begin
                  valid[fill_index] <= 1'b1;
                  o_rdata           <= i_bus_rdata;
                  o_bus_request     <= 1'b0;
                  o_ready           <= 1'b1;
                  state             <= DONE;
               end
            end
            WRITE: begin
               if (i_bus_ready) begin
                  o_bus_request <= 1'b0;
                  o_ready       <= 1'b1;
                  state         <= DONE;
               end
            end
            DONE: begin
               if (!i_request) begin
                  o_ready <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
